// File: rtl/ad7763_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad7763_pkg
//  Description : Shared constants, receiver state type and sample helper for
//                the AD7763 data-port receiver and control-word writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad7763_pkg;

    localparam int FRAME_BITS  = 32;
    localparam int SAMPLE_BITS = 24;
    localparam int STATUS_BITS = 8;
    localparam int CNT_W       = $clog2(FRAME_BITS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Sign-extend the two's-complement sample field of a frame to 32 bits.
    function automatic logic [31:0] sign_extend_sample(input logic [FRAME_BITS-1:0] frame);
        return {{(32 - SAMPLE_BITS){frame[FRAME_BITS-1]}},
                frame[FRAME_BITS-1 -: SAMPLE_BITS]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad7763_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ad7763_sync_edge
//  Description : Multi-flop synchroniser for one asynchronous ADC line, with
//                an optional rising-edge detector on the synchronised output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad7763_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DETECT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
            $error("ad7763_sync_edge: SYNC_STAGES must be 2 or 3");
        end
    endgenerate

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic r_prev;

            // Remember the previous synchronised level for edge detection.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= o_q;
                end
            end

            assign o_rise = o_q & ~r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_ad7763_rx.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ad7763_rx
//  Description : Deserialises AD7763 SDO frames (24-bit sample + 8-bit status)
//                clocked by SCO and presents each sample as one sign-extended
//                AXI-Stream beat. Frames arriving while the held beat is
//                stalled are dropped and counted in a saturating counter.
//                Optional build macro AD7763_STATUS_EN adds m_axis_tuser
//                carrying the frame status byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_ad7763_rx
    import ad7763_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        adc_sco,
    input  logic                        adc_fso,
    input  logic                        adc_sdo,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
`ifdef AD7763_STATUS_EN
    output logic [STATUS_BITS-1:0]      m_axis_tuser,
`endif
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [15:0]                 overflow_cnt
);

    localparam logic [15:0]      c_ovf_max   = 16'hFFFF;
    localparam logic [CNT_W-1:0] c_cnt_start = CNT_W'(FRAME_BITS - 2);

    generate
        if (AXIS_TDATA_WIDTH != 32) begin : g_bad_width
            $error("axis_ad7763_rx: AXIS_TDATA_WIDTH must be 32");
        end
    endgenerate

    logic w_sco_q;
    logic w_sco_rise;
    logic w_fso_q;
    logic w_fso_rise;
    logic w_sdo_q;
    logic w_sdo_rise;
    logic w_unused;

    rx_state_t                  r_state;
    logic [FRAME_BITS-1:0]      r_shift;
    logic [CNT_W-1:0]           r_bit_cnt;
    logic                       r_load_req;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                       r_tvalid;
    logic [15:0]                r_ovf_cnt;

    // All three lines use identical synchroniser depth so they stay aligned.
    ad7763_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_sco (
        .clk    (aclk),
        .rst    (areset),
        .i_d    (adc_sco),
        .o_q    (w_sco_q),
        .o_rise (w_sco_rise)
    );

    ad7763_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sync_fso (
        .clk    (aclk),
        .rst    (areset),
        .i_d    (adc_fso),
        .o_q    (w_fso_q),
        .o_rise (w_fso_rise)
    );

    ad7763_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sync_sdo (
        .clk    (aclk),
        .rst    (areset),
        .i_d    (adc_sdo),
        .o_q    (w_sdo_q),
        .o_rise (w_sdo_rise)
    );

    // Only the SCO edge and the FSO/SDO levels are consumed.
    assign w_unused = &{1'b0, w_sco_q, w_fso_rise, w_sdo_rise};

    // Frame receiver: sample FSO/SDO on each SCO rising edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_load_req <= 1'b0;
        end else begin
            r_load_req <= 1'b0;
            if (w_sco_rise) begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_fso_q) begin
                            r_shift   <= {{(FRAME_BITS-1){1'b0}}, w_sdo_q};
                            r_bit_cnt <= c_cnt_start;
                            r_state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (!w_fso_q) begin
                            // Frame sync mid-frame: restart with this bit as the MSB.
                            r_shift   <= {{(FRAME_BITS-1){1'b0}}, w_sdo_q};
                            r_bit_cnt <= c_cnt_start;
                        end else begin
                            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdo_q};
                            if (r_bit_cnt == '0) begin
                                r_state    <= IDLE;
                                r_load_req <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef AD7763_STATUS_EN
    logic [STATUS_BITS-1:0] r_tuser;
`endif

    // Single-entry output register with drop-on-stall overflow counting.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_ovf_cnt <= '0;
`ifdef AD7763_STATUS_EN
            r_tuser   <= '0;
`endif
        end else begin
            if (r_load_req && (!r_tvalid || m_axis_tready)) begin
                r_tdata  <= sign_extend_sample(r_shift);
                r_tvalid <= 1'b1;
`ifdef AD7763_STATUS_EN
                r_tuser  <= r_shift[STATUS_BITS-1:0];
`endif
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (r_load_req && r_tvalid && !m_axis_tready && (r_ovf_cnt != c_ovf_max)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign overflow_cnt  = r_ovf_cnt;
`ifdef AD7763_STATUS_EN
    assign m_axis_tuser  = r_tuser;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_ad7763_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_ad7763_rx
//  Description : Self-checking bench for axis_ad7763_rx: directed frames,
//                latency, stall/overflow, resync, reset and a randomised
//                back-pressure run against a queue-based reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ad7763_rx;

    localparam int N_RAND = 300;

    logic        aclk    = 1'b0;
    logic        areset  = 1'b1;
    logic        adc_sco = 1'b0;
    logic        adc_fso = 1'b1;
    logic        adc_sdo = 1'b0;
    logic        tready  = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic [15:0] ovf;
`ifdef AD7763_STATUS_EN
    logic [7:0]  tuser;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];

    bit          rand_en   = 1'b0;
    bit          stall     = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_data = '0;

    axis_ad7763_rx #(
        .AXIS_TDATA_WIDTH (32),
        .SYNC_STAGES      (2)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .adc_sco       (adc_sco),
        .adc_fso       (adc_fso),
        .adc_sdo       (adc_sdo),
        .m_axis_tdata  (tdata),
`ifdef AD7763_STATUS_EN
        .m_axis_tuser  (tuser),
`endif
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .overflow_cnt  (ovf)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected stream word: the 24-bit sample read as a signed number.
    function automatic logic [31:0] exp_sample(input logic [31:0] f);
        logic signed [23:0] s;
        int                 v;
        s = f[31:8];
        v = s;
        return 32'(v);
    endfunction

    task automatic chk_rx(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (rx_q.size() > idx) ? rx_q[idx] : 32'hxxxx_xxxx;
        chk(tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge aclk);
        #1 tready = v;
    endtask

    // Drive frame bits lo..hi (bit 0 = MSB); FSO is low only during bit 0.
    task automatic send_bits(input logic [31:0] f, input int lo, input int hi, input bit chk_lat);
        @(negedge aclk);
        #2;
        for (int i = lo; i <= hi; i++) begin
            adc_sco = 1'b0;
            adc_sdo = f[31-i];
            adc_fso = (i == 0) ? 1'b0 : 1'b1;
            #20;
            adc_sco = 1'b1;
            if (chk_lat && i == 31) begin
                @(posedge aclk);
                repeat (2) @(posedge aclk);
                #1 chk("latency_e2_tvalid", 32'(tvalid), 32'd0);
                @(posedge aclk);
                #1 chk("latency_e3_tvalid", 32'(tvalid), 32'd1);
                chk("latency_e3_tdata", tdata, exp_sample(f));
`ifdef AD7763_STATUS_EN
                chk("latency_e3_tuser", 32'(tuser), 32'(f[7:0]));
`endif
            end else begin
                #20;
            end
        end
        adc_sco = 1'b0;
        adc_fso = 1'b1;
    endtask

    task automatic idle_sco(input int n);
        for (int i = 0; i < n; i++) begin
            adc_sco = 1'b0;
            #20;
            adc_sco = 1'b1;
            #20;
        end
        adc_sco = 1'b0;
    endtask

    // Randomised back-pressure while enabled.
    always @(posedge aclk) begin
        #1;
        if (rand_en) tready = !stall && ($urandom_range(0, 1) == 1);
    end

    // Beat collector and AXI-Stream hold-stability monitor.
    always @(negedge aclk) begin
        if (!areset && hold_prev) begin
            chk("axis_hold_tvalid", 32'(tvalid), 32'd1);
            chk("axis_hold_tdata", tdata, hold_data);
        end
        if (!areset && tvalid && tready) rx_q.push_back(tdata);
        hold_prev = !areset && tvalid && !tready;
        hold_data = tdata;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        int          ptr;
        int          ovf_base;

        // Reset state
        repeat (4) @(posedge aclk);
        #1;
        chk("reset_tvalid", 32'(tvalid), 32'd0);
        chk("reset_tdata", tdata, 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        areset = 1'b0;
        set_ready(1'b1);
        wait_cycles(4);

        // Single positive full-scale frame with latency check
        rx_q.delete();
        send_bits(32'h7FFFFFA5, 0, 31, 1'b1);
        wait_cycles(10);
        chk("t1_count", 32'(rx_q.size()), 32'd1);
        chk_rx("t1_data", 0, 32'h007FFFFF);

        // Negative full-scale and minus one
        rx_q.delete();
        send_bits(32'h80000000, 0, 31, 1'b0);
        wait_cycles(10);
        send_bits(32'hFFFFFF00, 0, 31, 1'b0);
        wait_cycles(10);
        chk("t2_count", 32'(rx_q.size()), 32'd2);
        chk_rx("t2_negfs", 0, 32'hFF800000);
        chk_rx("t2_minus1", 1, 32'hFFFFFFFF);

        // Stalled output across three frames
        set_ready(1'b0);
        rx_q.delete();
        send_bits(32'h00000100, 0, 31, 1'b0);
        send_bits(32'h00000200, 0, 31, 1'b0);
        send_bits(32'h00000300, 0, 31, 1'b0);
        wait_cycles(10);
        chk("t3_held_tvalid", 32'(tvalid), 32'd1);
        chk("t3_held_tdata", tdata, 32'h00000001);
        chk("t3_ovf", 32'(ovf), 32'd2);
        chk("t3_none_before_release", 32'(rx_q.size()), 32'd0);
        set_ready(1'b1);
        wait_cycles(5);
        chk("t3_count", 32'(rx_q.size()), 32'd1);
        chk_rx("t3_data", 0, 32'h00000001);
        chk("t3_tvalid_drained", 32'(tvalid), 32'd0);

        // Resync after a 12-bit partial frame
        rx_q.delete();
        send_bits(32'hABCDEF77, 0, 11, 1'b0);
        send_bits(32'h12345600, 0, 31, 1'b0);
        wait_cycles(10);
        chk("t4_count", 32'(rx_q.size()), 32'd1);
        chk_rx("t4_data", 0, 32'h00123456);

        // Reset at bit 20 of a frame
        rx_q.delete();
        send_bits(32'h55AA5500, 0, 19, 1'b0);
        @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        send_bits(32'h55AA5500, 20, 31, 1'b0);
        wait_cycles(10);
        chk("t5_no_beat", 32'(rx_q.size()), 32'd0);
        chk("t5_tvalid", 32'(tvalid), 32'd0);
        chk("t5_ovf_cleared", 32'(ovf), 32'd0);
        send_bits(32'hFEDCBA5A, 0, 31, 1'b0);
        wait_cycles(10);
        chk("t5_count", 32'(rx_q.size()), 32'd1);
        chk_rx("t5_data", 0, 32'hFFFEDCBA);
        chk("t5_ovf", 32'(ovf), 32'd0);

        // Randomised frames with random back-pressure and stalled stretches
        rx_q.delete();
        exp_q.delete();
        ovf_base = int'(ovf);
        rand_en  = 1'b1;
        for (int k = 0; k < N_RAND; k++) begin
            f     = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            send_bits(f, 0, 31, 1'b0);
            exp_q.push_back(exp_sample(f));
            idle_sco(8);
        end
        stall   = 1'b0;
        rand_en = 1'b0;
        set_ready(1'b1);
        wait_cycles(20);

        chk("rand_emitted_plus_dropped", 32'(rx_q.size() + int'(ovf) - ovf_base), 32'(N_RAND));
        chk("rand_some_dropped", 32'(int'(ovf) > ovf_base), 32'd1);
        chk("rand_some_emitted", 32'(rx_q.size() > 0), 32'd1);
        ptr = 0;
        foreach (rx_q[j]) begin
            while (ptr < exp_q.size() && exp_q[ptr] !== rx_q[j]) ptr++;
            chk("rand_in_order", 32'(ptr < exp_q.size()), 32'd1);
            ptr++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
